// File: rtl/mux_sched.sv
// Round-robin scheduler for the three-channel output mux: grants one channel at a time
// for up to BURST_LEN beats, parking the mux on the idle code 2'b11 when nobody is eligible.
module mux_sched #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req_i,
  input  logic [2:0]       en_i,
  output logic [1:0]       select_o,
  output logic [2:0]       grant_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] beat_cnt_o,
  output logic             start_o
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BURST_LEN - 1);

  state_e           state_q, state_d;
  logic [1:0]       g_q, g_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;

  logic [2:0] elig;
  logic [2:0] cand;
  logic       beat;
  logic       load;
  logic [1:0] load_ch;

  // Scan last+1, last+2, last (mod 3); caller guarantees cand is nonzero.
  function automatic logic [1:0] rr_pick(input logic [2:0] c, input logic [1:0] last);
    logic [1:0] n1;
    logic [1:0] n2;
    n1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    n2 = (n1 == 2'd2) ? 2'd0 : n1 + 2'd1;
    if (c[n1]) begin
      return n1;
    end else if (c[n2]) begin
      return n2;
    end
    return last;
  endfunction

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    load    = 1'b0;
    load_ch = g_q;
    elig    = req_i & en_i;
    beat    = elig[g_q];
    cand    = elig & ~(3'b001 << g_q);

    unique case (state_q)
      StIdle: begin
        if (|elig) begin
          load    = 1'b1;
          load_ch = rr_pick(elig, last_q);
        end
      end
      StGrant: begin
        if (!beat) begin
          if (|elig) begin
            load    = 1'b1;
            load_ch = rr_pick(elig, last_q);
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else if (cnt_q == LastBeat) begin
          // Burst exhausted: rotate if anyone else waits, otherwise regrant the same channel.
          load    = 1'b1;
          load_ch = (|cand) ? rr_pick(cand, last_q) : g_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d = StGrant;
      g_d     = load_ch;
      last_d  = load_ch;
      cnt_d   = '0;
      start_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      g_q     <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  assign busy_o     = (state_q == StGrant);
  assign select_o   = busy_o ? g_q : 2'b11;
  assign grant_o    = busy_o ? (3'b001 << g_q) : 3'b000;
  assign beat_cnt_o = cnt_q;
  assign start_o    = start_q;

endmodule

// File: doc/mux_sched.md
# mux_sched

Round-robin scheduler that drives the 2-bit `select` of the three-channel registered output mux. It shares the mux between its three requesters by granting one channel at a time for a bounded burst of beats. When no channel is eligible, it parks the mux on the idle code 2'b11, which makes the mux clear its output.

## Interface
- `BURST_LEN`, 4, maximum beats per grant before a forced rotation (legal range 1..2**CNT_W-1).
- `CNT_W`, 3, width of the beat counter.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_i`  in  3  per-channel request; bit k is tied to the mux's validk_i.
- `en_i`  in  3  per-channel enable; a channel with its bit at 0 is never granted.
- `select_o`  out  2  registered mux select: 2'b00/01/10 for channel 0/1/2, 2'b11 for idle.
- `grant_o`  out  3  registered one-hot grant, consistent with `select_o`; 3'b000 when idle.
- `busy_o`  out  1  registered; high while in GRANT.
- `beat_cnt_o`  out  CNT_W  registered count of beats taken in the current grant.
- `start_o`  out  1  registered one-cycle pulse in the first cycle of every grant, including a regrant of the same channel.

## Operation
- Eligible vector: `elig = req_i & en_i`.
- Internal state: FSM {IDLE, GRANT}, current channel `g`, `last` (last granted channel), beat counter `cnt`.
- Reset (async, immediate):
  - FSM = IDLE, `select_o` = 2'b11, `grant_o` = 0, `busy_o` = 0, `beat_cnt_o` = 0, `start_o` = 0.
  - `last` = 2, so channel 0 has first priority.
- Round-robin pick from a candidate set: scan `last+1`, `last+2`, `last` (mod 3); take the first set bit.
- IDLE:
  - If `elig` is nonzero: pick from `elig`, load `g`, `select_o`, `grant_o`, `last`; set `cnt` = 0, `start_o` = 1; go to GRANT.
  - Otherwise stay in IDLE with outputs at their idle values.
- GRANT, evaluated each cycle:
  - beat = `req_i[g] & en_i[g]`.
  - drop = !beat.
  - end = beat and (`cnt` == BURST_LEN-1).
- If neither drop nor end: on a beat, `cnt` increments; otherwise `cnt` holds. Grant holds.
- On end (the BURST_LEN-th beat completes at this edge):
  - Candidates = `elig` with bit g cleared.
  - If any candidate: switch to the pick next cycle.
  - Else if `elig[g]`: regrant g with `cnt` = 0 and `start_o` = 1.
  - Else: go to IDLE.
- On drop (no beat this cycle, so `cnt` is not incremented):
  - Candidates = `elig`; bit g is already 0.
  - If nonzero: switch to the pick. Else: go to IDLE.
- Every new grant, whether from IDLE, a switch or a regrant, sets `cnt` = 0, `start_o` = 1, and updates `last`. There is no idle bubble between back-to-back grants.
- `beat_cnt_o` always equals `cnt`.

## Timing
- Request-to-grant latency: `req_i[k]` high at edge N while IDLE gives `select_o` = k after edge N. The mux captures the first beat at edge N+1, and its data and valid outputs appear after N+1.
- Beat definition: a cycle with `select_o` == g and `req_i[g]` high. The mux samples it at the same edge where `cnt` increments, or where the grant rotates when the beat is the last of the burst.
- Steady all-request case: each channel holds `select_o` for exactly BURST_LEN cycles.
- Clearing `en_i[g]` mid-burst behaves as a drop: release at the next edge, and that cycle is not counted.
- Dropping `req_i` and raising it again in the same cycle as a new request from another channel: round-robin order decides.
- With BURST_LEN = 1, every beat rotates the grant.
- `rst` asserted mid-grant forces all outputs to their reset values immediately. The first grant after `rst` deasserts follows the IDLE rule with `last` = 2.
- `select_o` never takes a value outside {00, 01, 10, 11}, and never selects a channel with its `en_i` bit low at the time of the grant.

## Test plan
- Reset mid-grant: ch1 granted with `cnt` = 2, then assert `rst` → `select_o` = 11, `grant_o` = 000, `busy_o` = 0, `beat_cnt_o` = 0 without waiting for a clock edge. Release reset with `req_i` = 111 → `select_o` = 00 after one edge.
- Full contention, BURST_LEN = 4: `req_i` = 111, `en_i` = 111 → `select_o` runs 00 ×4, 01 ×4, 10 ×4, 00… `start_o` pulses every 4th cycle, and `beat_cnt_o` runs 0,1,2,3 in each window.
- Single requester: `req_i` = 010 held → `select_o` stays 01, `start_o` pulses every 4 cycles, and `beat_cnt_o` wraps 3→0 with no idle cycle.
- Drop with waiting requester: ch0 granted, 2 beats taken, then `req_i` = 100 → `select_o` = 10 at the next edge and `start_o` = 1. The drop cycle is not counted.
- Enable masking: `req_i` = 111, `en_i` = 101 → `select_o` alternates 00/10 in 4-cycle bursts. Clearing `en_i[2]` mid-burst gives `select_o` = 00 at the next edge.
- Idle return: all requests deasserted during a grant → `select_o` = 11, `grant_o` = 000, `busy_o` = 0 at the next edge, and these values hold while `req_i` = 000.
